// File: rtl/branch_pkg.sv
// Shared definitions for the LEGv8 branch sequencer: opcodes, PC-select codes,
// sequencer states, ARM condition codes and control-word bit positions.
package branch_pkg;

    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [5:0]  OP_BL    = 6'b100101;
    localparam logic [10:0] OP_BR    = 11'b11010110000;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;

    typedef enum logic [1:0] {
        PSEL_HOLD  = 2'b00,
        PSEL_PC4   = 2'b01,
        PSEL_REG_A = 2'b10,
        PSEL_PC_K  = 2'b11
    } psel_e;

    typedef enum logic [2:0] {
        IDLE,
        TEST,
        LINK,
        BRANCH,
        SKIP
    } state_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    localparam logic [4:0] FSEL_PASS_B = 5'b10100;

    // Fixed low-order fields; register fields sit above Fsel and scale with REG_AW.
    localparam int unsigned CW_SL       = 0;
    localparam int unsigned CW_PCSEL    = 1;
    localparam int unsigned CW_BSEL     = 2;
    localparam int unsigned CW_EN_PC    = 3;
    localparam int unsigned CW_EN_B     = 4;
    localparam int unsigned CW_EN_ALU   = 5;
    localparam int unsigned CW_EN_MEM   = 6;
    localparam int unsigned CW_RAMW     = 7;
    localparam int unsigned CW_REGW     = 8;
    localparam int unsigned CW_FSEL_LSB = 9;
    localparam int unsigned CW_FSEL_W   = 5;

endpackage

// File: rtl/cond_eval.sv
// ARM condition-code evaluator: decides whether a B.cond is taken from NZCV.
module cond_eval
    import branch_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] nzcv_i,
    output logic       taken_o
);

    logic n, z, c, v;
    assign {n, z, c, v} = nzcv_i;

    always_comb begin
        taken_o = 1'b1;
        case (cond_i)
            COND_EQ: taken_o = z;
            COND_NE: taken_o = !z;
            COND_CS: taken_o = c;
            COND_CC: taken_o = !c;
            COND_MI: taken_o = n;
            COND_PL: taken_o = !n;
            COND_VS: taken_o = v;
            COND_VC: taken_o = !v;
            COND_HI: taken_o = c && !z;
            COND_LS: taken_o = !(c && !z);
            COND_GE: taken_o = (n == v);
            COND_LT: taken_o = (n != v);
            COND_GT: taken_o = !z && (n == v);
            COND_LE: taken_o = !(!z && (n == v));
            default: taken_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_ctrl_fsm.sv
// Multi-cycle LEGv8 branch sequencer emitting one datapath control word per cycle.
// Optional taken/not-taken counters are built when BRANCH_STATS_EN is defined.
module branch_ctrl_fsm
    import branch_pkg::*;
#(
    parameter  int unsigned DATA_W   = 64,
    parameter  int unsigned REG_AW   = 5,
    parameter  int unsigned LINK_REG = 30,
    localparam int unsigned CW_W     = 2 + 3*REG_AW + 5 + 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       instruction,
    input  logic [3:0]        status,
    input  logic              alu_zero,
    output logic [CW_W-1:0]   controlword,
    output logic [DATA_W-1:0] K,
    output logic              busy,
    output logic              done,
    output logic              illegal
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]       taken_cnt,
    output logic [31:0]       nottaken_cnt
`endif
);

    localparam int unsigned SB_LSB   = CW_FSEL_LSB + CW_FSEL_W;
    localparam int unsigned SA_LSB   = SB_LSB + REG_AW;
    localparam int unsigned DA_LSB   = SA_LSB + REG_AW;
    localparam int unsigned PSEL_LSB = DA_LSB + REG_AW;

    state_e             state_q, state_d;
    logic [4:0]         rt_q, rt_d;
    logic [4:0]         rn_q, rn_d;
    logic               br_q, br_d;
    logic               cbnz_q, cbnz_d;
    logic [DATA_W-1:0]  k_q, k_d;
    logic               illegal_q, illegal_d;
    logic               cond_taken;

    cond_eval u_cond_eval (
        .cond_i  (instruction[3:0]),
        .nzcv_i  (status),
        .taken_o (cond_taken)
    );

    // Only the fields the later states need are kept from the accepted instruction.
    always_comb begin
        state_d   = state_q;
        rt_d      = rt_q;
        rn_d      = rn_q;
        br_d      = br_q;
        cbnz_d    = cbnz_q;
        k_d       = k_q;
        illegal_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rt_d   = instruction[4:0];
                    rn_d   = instruction[9:5];
                    br_d   = (instruction[31:21] == OP_BR);
                    cbnz_d = (instruction[31:24] == OP_CBNZ);
                    if (instruction[31:26] == OP_B) begin
                        state_d = BRANCH;
                        k_d     = {{(DATA_W-26){instruction[25]}}, instruction[25:0]};
                    end else if (instruction[31:26] == OP_BL) begin
                        state_d = LINK;
                        k_d     = {{(DATA_W-26){instruction[25]}}, instruction[25:0]};
                    end else if (instruction[31:21] == OP_BR) begin
                        state_d = BRANCH;
                        k_d     = '0;
                    end else if (instruction[31:24] == OP_CBZ ||
                                 instruction[31:24] == OP_CBNZ) begin
                        state_d = TEST;
                        k_d     = {{(DATA_W-19){instruction[23]}}, instruction[23:5]};
                    end else if (instruction[31:24] == OP_BCOND) begin
                        state_d = cond_taken ? BRANCH : SKIP;
                        k_d     = {{(DATA_W-19){instruction[23]}}, instruction[23:5]};
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            TEST:    state_d = (cbnz_q ? !alu_zero : alu_zero) ? BRANCH : SKIP;
            LINK:    state_d = BRANCH;
            BRANCH:  state_d = IDLE;
            SKIP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            rt_q      <= '0;
            rn_q      <= '0;
            br_q      <= 1'b0;
            cbnz_q    <= 1'b0;
            k_q       <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rt_q      <= rt_d;
            rn_q      <= rn_d;
            br_q      <= br_d;
            cbnz_q    <= cbnz_d;
            k_q       <= k_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        controlword = '0;
        if (state_q != IDLE) begin
            controlword[DA_LSB +: REG_AW] = '1;
            controlword[SA_LSB +: REG_AW] = '1;
            controlword[SB_LSB +: REG_AW] = '1;
        end
        case (state_q)
            TEST: begin
                controlword[SB_LSB +: REG_AW]         = REG_AW'(rt_q);
                controlword[CW_FSEL_LSB +: CW_FSEL_W] = FSEL_PASS_B;
                controlword[CW_EN_ALU]                = 1'b1;
            end
            LINK: begin
                controlword[DA_LSB +: REG_AW] = REG_AW'(LINK_REG);
                controlword[CW_EN_PC]         = 1'b1;
                controlword[CW_REGW]          = 1'b1;
            end
            BRANCH: begin
                if (br_q) begin
                    controlword[PSEL_LSB +: 2]    = PSEL_REG_A;
                    controlword[SA_LSB +: REG_AW] = REG_AW'(rn_q);
                    controlword[CW_EN_B]          = 1'b1;
                end else begin
                    controlword[PSEL_LSB +: 2] = PSEL_PC_K;
                end
            end
            SKIP:    controlword[PSEL_LSB +: 2] = PSEL_PC4;
            default: ;
        endcase
        controlword[CW_RAMW]   = 1'b0;
        controlword[CW_EN_MEM] = 1'b0;
        controlword[CW_SL]     = 1'b0;
        controlword[CW_BSEL]   = 1'b0;
        controlword[CW_PCSEL]  = 1'b0;
    end

    assign K       = k_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == BRANCH) || (state_q == SKIP);
    assign illegal = illegal_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] taken_q, nottaken_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            taken_q    <= '0;
            nottaken_q <= '0;
        end else begin
            if (state_q == BRANCH && taken_q != '1) taken_q <= taken_q + 32'd1;
            if (state_q == SKIP && nottaken_q != '1) nottaken_q <= nottaken_q + 32'd1;
        end
    end

    assign taken_cnt    = taken_q;
    assign nottaken_cnt = nottaken_q;
`endif

endmodule
